// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each owner keeps the port for a burst; ownership changes without a bubble when another producer is waiting.

module fifo_wr_arbiter_lane #(
   parameter int DATA_W = 8
) (
   input  logic              sel,
   input  logic              req,
   input  logic              full,
   input  logic [DATA_W-1:0] data,
   output logic              gnt,
   output logic [DATA_W-1:0] data_out
);
   assign gnt      = sel & req & ~full;
   assign data_out = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   localparam int SRC_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_wr_data,
   output logic [SRC_W-1:0]          fifo_wr_src,
   output logic                      busy,
   output logic [SRC_W-1:0]          owner
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   logic [0:0]                     state;
   logic [SRC_W-1:0]               rr_ptr;
   logic [CNT_W-1:0]               beat_cnt;
   logic [NUM_REQ-1:0]             owner_oh;
   logic [NUM_REQ-1:0][DATA_W-1:0] lane_din;
   logic [NUM_REQ-1:0][DATA_W-1:0] lane_dout;
   logic [NUM_REQ-1:0]             hand_mask;
   logic [SRC_W-1:0]               owner_nxt;
   logic req_own, last_own, xfer, cnt_max, burst_end;

   // Nearest set bit at or after ptr, wrapping at NUM_REQ-1 for any NUM_REQ.
   function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                input logic [SRC_W-1:0]   ptr);
      int best;
      int d;
      rr_pick = '0;
      best    = NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = i - int'(ptr);
         if (d < 0) d = d + NUM_REQ;
         if (mask[i] && d < best) begin
            best    = d;
            rr_pick = SRC_W'(i);
         end
      end
   endfunction

   assign lane_din = req_data;
   assign busy     = (state == S_BURST);

   always_comb begin
      owner_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == SRC_W'(i));
   end

   assign req_own   = |(req & owner_oh);
   assign last_own  = |(req_last & owner_oh);
   // Reset gates the write so an aborted burst never lands a beat.
   assign xfer      = busy & ~reset & req_own & ~fifo_full;
   assign cnt_max   = (beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST);
   assign burst_end = (xfer & (last_own | cnt_max)) | (busy & ~req_own);
   assign hand_mask = req & ~owner_oh;
   assign owner_nxt = (owner == SRC_W'(NUM_REQ - 1)) ? '0 : owner + SRC_W'(1);

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_lane
         fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .sel      (busy & ~reset & owner_oh[g]),
            .req      (req[g]),
            .full     (fifo_full),
            .data     (lane_din[g]),
            .gnt      (gnt[g]),
            .data_out (lane_dout[g])
         );
      end
   endgenerate

   always_comb begin
      fifo_wr_data = '0;
      for (int i = 0; i < NUM_REQ; i++) fifo_wr_data = fifo_wr_data | lane_dout[i];
   end

   assign fifo_wr_en  = xfer;
   assign fifo_wr_src = xfer ? owner : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  owner    <= rr_pick(req, rr_ptr);
                  beat_cnt <= '0;
                  state    <= S_BURST;
               end
            end
            S_BURST: begin
               if (burst_end) begin
                  rr_ptr   <= owner_nxt;
                  beat_cnt <= '0;
                  if (|hand_mask) owner <= rr_pick(hand_mask, owner_nxt);
                  else            state <= S_IDLE;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
